// File: rtl/uart_rx_axis.sv
// UART receiver: 2-flop synchronized rxd, mid-bit sampling, prescale*8 clocks per bit,
// received words presented on an AXI4-Stream master with framing/overrun status pulses.
module uart_rx_axis #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_next;
  logic                  rxd_meta, rxd_s;
  logic [18:0]           prescale_cnt, cnt_next;
  logic [3:0]            bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next, tdata_next;
  logic                  tvalid_next, busy_next, overrun_next, frame_next;
  logic [18:0]           half_load, full_load;

  assign half_load = {1'b0, prescale, 2'b00} - 19'd2;
  assign full_load = {prescale, 3'b000} - 19'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      prescale_cnt  <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      busy          <= 1'b0;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state         <= state_next;
      prescale_cnt  <= cnt_next;
      bit_cnt       <= bit_next;
      shreg         <= shreg_next;
      m_axis_tdata  <= tdata_next;
      m_axis_tvalid <= tvalid_next;
      busy          <= busy_next;
      overrun_error <= overrun_next;
      frame_error   <= frame_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = prescale_cnt;
    bit_next     = bit_cnt;
    shreg_next   = shreg;
    tdata_next   = m_axis_tdata;
    tvalid_next  = m_axis_tvalid;
    busy_next    = busy;
    overrun_next = 1'b0;
    frame_next   = 1'b0;

    if (m_axis_tvalid && m_axis_tready)
      tvalid_next = 1'b0;

    unique case (state)
      IDLE: begin
        if (prescale != 16'd0 && !rxd_s) begin
          cnt_next   = half_load;
          // DATA_WIDTH=14 wraps to 0 here; the modulo-16 countdown still lands on 1 after the last bit
          bit_next   = 4'(DATA_WIDTH + 2);
          busy_next  = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (prescale_cnt != '0) begin
          cnt_next = prescale_cnt - 19'd1;
        end else if (rxd_s) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next   = full_load;
          bit_next   = bit_cnt - 4'd1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (prescale_cnt != '0) begin
          cnt_next = prescale_cnt - 19'd1;
        end else begin
          shreg_next                 = shreg >> 1;
          shreg_next[DATA_WIDTH-1]   = rxd_s;
          cnt_next                   = full_load;
          bit_next                   = bit_cnt - 4'd1;
          if (bit_cnt == 4'd2)
            state_next = STOP;
        end
      end
      STOP: begin
        if (prescale_cnt != '0) begin
          cnt_next = prescale_cnt - 19'd1;
        end else begin
          busy_next  = 1'b0;
          state_next = IDLE;
          if (rxd_s) begin
            tdata_next   = shreg;
            tvalid_next  = 1'b1;
            overrun_next = m_axis_tvalid && !m_axis_tready;
          end else begin
            frame_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis; expectations come from frame timing arithmetic
// (edge 0 = clock edge right before rxd falls, stop sampled at edge 4P+2+8P*(DW+1)).
module tb_uart_rx_axis;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rxd;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          busy;
  logic          overrun_error;
  logic          frame_error;
  logic [15:0]   prescale;

  int checks = 0;
  int errors = 0;

  uart_rx_axis #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .overrun_error(overrun_error), .frame_error(frame_error), .prescale(prescale)
  );

  always #5 clk = ~clk;

  function automatic int unsigned done_edge(input int unsigned p);
    return 4*p + 2 + 8*p*(DW + 1);
  endfunction

  // Caller is 1 time unit past edge 0; each bit is held for 8p clocks.
  task automatic drive_frame(input logic [DW-1:0] d, input int unsigned p, input bit stop_ok);
    rxd = 1'b0;
    repeat (8*p) @(posedge clk);
    #1;
    for (int unsigned i = 0; i < DW; i++) begin
      rxd = d[i];
      repeat (8*p) @(posedge clk);
      #1;
    end
    if (stop_ok) begin
      rxd = 1'b1;
      repeat (8*p) @(posedge clk);
      #1;
    end else begin
      rxd = 1'b0;
      repeat (4*p) @(posedge clk);
      #1;
      rxd = 1'b1;
      repeat (4*p) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxd = 1'b1; m_axis_tready = 1'b1; prescale = 16'd1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, m_axis_tvalid, frame_error, overrun_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, m_axis_tvalid, frame_error, overrun_error});
    end
    checks++;
    if (m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL reset_tdata: got %0h expected 0", m_axis_tdata);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_frames();
    logic [DW-1:0] d;
    int unsigned   p, done;
    logic [3:0]    exp;
    m_axis_tready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      d = (f == 0) ? DW'(8'hA5) : DW'($urandom);
      p = (f == 0) ? 1 : $urandom_range(1, 3);
      prescale = 16'(p);
      done = done_edge(p);
      @(posedge clk);
      #1;
      fork
        drive_frame(d, p, 1'b1);
        begin
          for (int unsigned k = 1; k <= done + 1; k++) begin
            @(posedge clk);
            #1;
            exp = {k >= 3 && k < done, k == done, 1'b0, 1'b0};
            checks++;
            if ({busy, m_axis_tvalid, frame_error, overrun_error} !== exp) begin
              errors++;
              $display("FAIL frames_flags f=%0d edge=%0d: got %b expected %b", f, k,
                       {busy, m_axis_tvalid, frame_error, overrun_error}, exp);
            end
            if (k == done) begin
              checks++;
              if (m_axis_tdata !== d) begin
                errors++;
                $display("FAIL frames_tdata f=%0d: got %0h expected %0h", f, m_axis_tdata, d);
              end
            end
          end
        end
      join
    end
  endtask

  task automatic test_back_to_back();
    int unsigned p, done1, done2, ov_cnt;
    logic [2:0]  exp;
    p = 4; prescale = 16'(p); m_axis_tready = 1'b0; ov_cnt = 0;
    done1 = done_edge(p);
    done2 = 8*p*(DW + 2) + done1;
    @(posedge clk);
    #1;
    fork
      begin
        drive_frame(DW'(8'h00), p, 1'b1);
        drive_frame(DW'(8'hFF), p, 1'b1);
      end
      begin
        for (int unsigned k = 1; k <= done2 + 2; k++) begin
          @(posedge clk);
          #1;
          if (overrun_error === 1'b1) ov_cnt++;
          exp = {k >= done1, k == done2, 1'b0};
          checks++;
          if ({m_axis_tvalid, overrun_error, frame_error} !== exp) begin
            errors++;
            $display("FAIL b2b_flags edge=%0d: got %b expected %b", k,
                     {m_axis_tvalid, overrun_error, frame_error}, exp);
          end
          if (k >= done1) begin
            checks++;
            if (m_axis_tdata !== ((k < done2) ? DW'(8'h00) : DW'(8'hFF))) begin
              errors++;
              $display("FAIL b2b_tdata edge=%0d: got %0h expected %0h", k, m_axis_tdata,
                       (k < done2) ? DW'(8'h00) : DW'(8'hFF));
            end
          end
        end
      end
    join
    checks++;
    if (ov_cnt != 1) begin
      errors++;
      $display("FAIL b2b_overrun_count: got %0d expected 1", ov_cnt);
    end
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got %b expected 0", m_axis_tvalid);
    end
  endtask

  task automatic test_frame_error();
    int unsigned p, done;
    logic [3:0]  exp;
    p = 2; prescale = 16'(p); m_axis_tready = 1'b1;
    done = done_edge(p);
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      fork
        drive_frame((r == 0) ? DW'(8'h3C) : DW'(8'h42), p, r != 0);
        begin
          for (int unsigned k = 1; k <= done + 3; k++) begin
            @(posedge clk);
            #1;
            exp = {k >= 3 && k < done, r != 0 && k == done, r == 0 && k == done, 1'b0};
            checks++;
            if ({busy, m_axis_tvalid, frame_error, overrun_error} !== exp) begin
              errors++;
              $display("FAIL ferr_flags r=%0d edge=%0d: got %b expected %b", r, k,
                       {busy, m_axis_tvalid, frame_error, overrun_error}, exp);
            end
            if (r != 0 && k == done) begin
              checks++;
              if (m_axis_tdata !== DW'(8'h42)) begin
                errors++;
                $display("FAIL ferr_recover_tdata: got %0h expected 42", m_axis_tdata);
              end
            end
          end
        end
      join
    end
  endtask

  task automatic test_glitch();
    int unsigned p, len;
    logic [3:0]  exp;
    m_axis_tready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      p   = (g == 0) ? 2 : $urandom_range(1, 4);
      len = (g == 0) ? 3 : $urandom_range(1, 4*p - 1);
      prescale = 16'(p);
      @(posedge clk);
      #1;
      fork
        begin
          rxd = 1'b0;
          repeat (len) @(posedge clk);
          #1;
          rxd = 1'b1;
        end
        begin
          for (int unsigned k = 1; k <= 4*p + 6; k++) begin
            @(posedge clk);
            #1;
            exp = {k >= 3 && k < 4*p + 2, 3'b000};
            checks++;
            if ({busy, m_axis_tvalid, frame_error, overrun_error} !== exp) begin
              errors++;
              $display("FAIL glitch_flags p=%0d len=%0d edge=%0d: got %b expected %b", p, len, k,
                       {busy, m_axis_tvalid, frame_error, overrun_error}, exp);
            end
          end
        end
      join
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_frame();
    int unsigned   p, done;
    logic [DW-1:0] d;
    logic [3:0]    exp;
    p = 1; prescale = 16'(p); m_axis_tready = 1'b1;
    done = done_edge(p);
    // Upper data bits are 1 so the line stays idle-high once reset aborts the frame.
    d = {4'hF, 4'($urandom)};
    @(posedge clk);
    #1;
    fork
      drive_frame(d, p, 1'b1);
      begin
        for (int unsigned k = 1; k <= done + 2; k++) begin
          @(posedge clk);
          #1;
          exp = {k >= 3 && k < 40, 3'b000};
          checks++;
          if ({busy, m_axis_tvalid, frame_error, overrun_error} !== exp) begin
            errors++;
            $display("FAIL rstmid_flags edge=%0d: got %b expected %b", k,
                     {busy, m_axis_tvalid, frame_error, overrun_error}, exp);
          end
          if (k == 39) rst_n = 1'b0;
          if (k == 40) rst_n = 1'b1;
        end
      end
    join
    @(posedge clk);
    #1;
    fork
      drive_frame(DW'(8'h81), p, 1'b1);
      begin
        for (int unsigned k = 1; k <= done + 1; k++) begin
          @(posedge clk);
          #1;
          exp = {k >= 3 && k < done, k == done, 2'b00};
          checks++;
          if ({busy, m_axis_tvalid, frame_error, overrun_error} !== exp) begin
            errors++;
            $display("FAIL rstmid_next_flags edge=%0d: got %b expected %b", k,
                     {busy, m_axis_tvalid, frame_error, overrun_error}, exp);
          end
          if (k == done) begin
            checks++;
            if (m_axis_tdata !== DW'(8'h81)) begin
              errors++;
              $display("FAIL rstmid_next_tdata: got %0h expected 81", m_axis_tdata);
            end
          end
        end
      end
    join
  endtask

  task automatic test_tready_toggle();
    int unsigned p, done;
    p = 1; prescale = 16'(p); m_axis_tready = 1'b0;
    done = done_edge(p);
    @(posedge clk);
    #1;
    fork
      drive_frame(DW'(8'h55), p, 1'b1);
      begin
        repeat (done) @(posedge clk);
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, DW'(8'h55)}) begin
          errors++;
          $display("FAIL hold_first: got %b/%0h expected 1/55", m_axis_tvalid, m_axis_tdata);
        end
      end
    join
    @(posedge clk);
    #1;
    fork
      drive_frame(DW'(8'h66), p, 1'b1);
      begin
        for (int unsigned k = 1; k <= done + 1; k++) begin
          @(posedge clk);
          #1;
          checks++;
          if (k < done) begin
            if ({m_axis_tvalid, m_axis_tdata, overrun_error} !== {1'b1, DW'(8'h55), 1'b0}) begin
              errors++;
              $display("FAIL hold_stable edge=%0d: got %b/%0h/%b expected 1/55/0", k,
                       m_axis_tvalid, m_axis_tdata, overrun_error);
            end
          end else if (k == done) begin
            if ({m_axis_tvalid, m_axis_tdata, overrun_error} !== {1'b1, DW'(8'h66), 1'b0}) begin
              errors++;
              $display("FAIL simul_accept: got %b/%0h/%b expected 1/66/0",
                       m_axis_tvalid, m_axis_tdata, overrun_error);
            end
          end else begin
            if ({m_axis_tvalid, overrun_error} !== 2'b10) begin
              errors++;
              $display("FAIL simul_after: got %b/%b expected 1/0", m_axis_tvalid, overrun_error);
            end
          end
          if (k == done - 1) m_axis_tready = 1'b1;
          if (k == done)     m_axis_tready = 1'b0;
        end
      end
    join
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL toggle_drain: got %b expected 0", m_axis_tvalid);
    end
  endtask

  task automatic test_prescale_zero();
    prescale = 16'd0;
    for (int i = 0; i < 200; i++) begin
      rxd = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({busy, m_axis_tvalid} !== 2'b00) begin
        errors++;
        $display("FAIL prescale_zero cycle=%0d: got %b expected 00", i, {busy, m_axis_tvalid});
      end
    end
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    prescale = 16'd1;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_tready_toggle();
    test_prescale_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
